// File: rtl/bioee_adc_pkg.sv
// ============================================================================
// bioee_adc_pkg : shared state encoding and default constants for the ADC read path
// Revision      : 1.0
// ============================================================================
`default_nettype none

package bioee_adc_pkg;

  localparam int CLK_DIV_DEFAULT = 200;
  localparam int ADC_FRAME_BITS  = 16;

  typedef logic [2:0] adc_state_t;

  localparam adc_state_t ST_IDLE  = 3'd0;
  localparam adc_state_t ST_SETUP = 3'd1;
  localparam adc_state_t ST_SHIFT = 3'd2;
  localparam adc_state_t ST_HOLD  = 3'd3;
  localparam adc_state_t ST_GAP   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sclk_phase_gen.sv
// ============================================================================
// sclk_phase_gen : half-period timer, sclk generator and registered edge ticks
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sclk_phase_gen #(
  parameter int HALF = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_rise_en,
  output logic o_phase_end,
  output logic o_rise_tick,
  output logic o_fall_tick,
  output logic o_adc_sclk
);

  localparam int              CW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0]   C_CNT_MAX = CW'(HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          r_rise;
  logic          r_fall;
  logic          w_phase_end;

  assign w_phase_end = (r_cnt == C_CNT_MAX);

  // Ticks are registered so they are high in the first cycle of the new sclk level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= w_phase_end ? '0 : r_cnt + 1'b1;
      r_rise <= w_phase_end && i_rise_en && !r_sclk;
      r_fall <= w_phase_end && r_sclk;
      if (w_phase_end) begin
        r_sclk <= i_rise_en && !r_sclk;
      end
    end
  end

  assign o_phase_end = w_phase_end;
  assign o_rise_tick = r_rise;
  assign o_fall_tick = r_fall;
  assign o_adc_sclk  = r_sclk;

endmodule

`default_nettype wire

// File: rtl/adc_serial_reader.sv
// ============================================================================
// adc_serial_reader : SPI-style ADC read engine with a single-entry valid/ready output
// Revision          : 1.0
// ============================================================================
`default_nettype none

module adc_serial_reader
  import bioee_adc_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEFAULT,
  parameter int FRAME_BITS  = ADC_FRAME_BITS,
  parameter int DATA_BITS   = 16,
  parameter int GAP_PERIODS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_start_trig,
  input  logic                 i_adc_dout,
  output logic                 o_adc_sclk,
  output logic                 o_adc_cs_n,
  output logic [DATA_BITS-1:0] o_dout,
  output logic                 o_dout_valid,
  input  logic                 i_dout_ready,
  output logic                 o_busy,
  output logic                 o_overrun,
  output logic [7:0]           o_overrun_count
);

  localparam int            HALF        = CLK_DIV / 2;
  localparam int            BW          = $clog2(FRAME_BITS + 1);
  localparam int            GW          = $clog2(2 * GAP_PERIODS);
  localparam logic [BW-1:0] C_BITS_LAST = BW'(FRAME_BITS);
  localparam logic [GW-1:0] C_GAP_LAST  = GW'(2 * GAP_PERIODS - 1);

  adc_state_t           r_state;
  logic                 r_cs_n;
  logic                 r_busy;
  logic                 r_deliver;
  logic [BW-1:0]        r_bit_cnt;
  logic [GW-1:0]        r_gap_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid;
  logic                 r_overrun;
  logic [7:0]           r_ovr_cnt;

  logic w_phase_end;
  logic w_rise_tick;
  logic w_fall_tick;
  logic w_sclk;
  logic w_rise_en;
  logic w_shift_done;
  logic w_run;

  assign w_run        = (r_state != ST_IDLE);
  // The last bit's low phase must end without a further rising edge.
  assign w_rise_en    = (r_state == ST_SETUP) ||
                        ((r_state == ST_SHIFT) && (r_bit_cnt != C_BITS_LAST));
  assign w_shift_done = (r_state == ST_SHIFT) && w_phase_end && !w_sclk &&
                        (r_bit_cnt == C_BITS_LAST);

  sclk_phase_gen #(
    .HALF (HALF)
  ) u_sclk_phase_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (w_run),
    .i_rise_en   (w_rise_en),
    .o_phase_end (w_phase_end),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick),
    .o_adc_sclk  (w_sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_deliver <= 1'b0;
    end else begin
      r_deliver <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_enable || i_start_trig) begin
            r_state <= ST_SETUP;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_phase_end) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_shift_done) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_phase_end) begin
            r_state   <= ST_GAP;
            r_cs_n    <= 1'b1;
            r_deliver <= 1'b1;
          end
        end
        ST_GAP: begin
          if (w_phase_end && (r_gap_cnt == C_GAP_LAST)) begin
            if (i_enable) begin
              r_state <= ST_SETUP;
              r_cs_n  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state != ST_SHIFT) begin
        r_bit_cnt <= '0;
      end else if (w_fall_tick) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (r_state != ST_GAP) begin
        r_gap_cnt <= '0;
      end else if (w_phase_end) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end

      // Older bits fall off the top, so only the last DATA_BITS of the frame remain.
      if (w_rise_tick) begin
        r_shift <= {r_shift[DATA_BITS-2:0], i_adc_dout};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_ovr_cnt <= 8'd0;
    end else begin
      r_overrun <= 1'b0;
      if (r_deliver) begin
        if (!r_valid || i_dout_ready) begin
          r_dout  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
          if (r_ovr_cnt != 8'hFF) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
          end
        end
      end else if (r_valid && i_dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_adc_sclk      = w_sclk;
  assign o_adc_cs_n      = r_cs_n;
  assign o_dout          = r_dout;
  assign o_dout_valid    = r_valid;
  assign o_busy          = r_busy;
  assign o_overrun       = r_overrun;
  assign o_overrun_count = r_ovr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_reader.sv
// ============================================================================
// tb_adc_serial_reader : directed bench for adc_serial_reader (CLK_DIV = 4)
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_adc_serial_reader;

  localparam int CLK_DIV     = 4;
  localparam int FRAME_BITS  = 16;
  localparam int DATA_BITS   = 16;
  localparam int GAP_PERIODS = 4;

  logic                 clk          = 1'b0;
  logic                 rst_n        = 1'b0;
  logic                 enable       = 1'b0;
  logic                 start_trig   = 1'b0;
  logic                 adc_dout     = 1'b0;
  logic                 dout_ready   = 1'b0;
  logic                 adc_sclk;
  logic                 adc_cs_n;
  logic [DATA_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 busy;
  logic                 overrun;
  logic [7:0]           overrun_count;

  adc_serial_reader #(
    .CLK_DIV     (CLK_DIV),
    .FRAME_BITS  (FRAME_BITS),
    .DATA_BITS   (DATA_BITS),
    .GAP_PERIODS (GAP_PERIODS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_enable        (enable),
    .i_start_trig    (start_trig),
    .i_adc_dout      (adc_dout),
    .o_adc_sclk      (adc_sclk),
    .o_adc_cs_n      (adc_cs_n),
    .o_dout          (dout),
    .o_dout_valid    (dout_valid),
    .i_dout_ready    (dout_ready),
    .o_busy          (busy),
    .o_overrun       (overrun),
    .o_overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model: first bit on cs_n fall, next bit after each sclk fall.
  logic [15:0] adc_q[$];
  logic [15:0] adc_cur = 16'h0;
  int          adc_idx = 0;
  bit          frame_on = 1'b0;

  always @(negedge adc_cs_n or posedge adc_cs_n or negedge adc_sclk) begin
    if (adc_cs_n) begin
      frame_on = 1'b0;
    end else if (!frame_on) begin
      frame_on = 1'b1;
      adc_cur  = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
      adc_idx  = 15;
      adc_dout = adc_cur[adc_idx];
    end else if (adc_idx > 0) begin
      adc_idx  = adc_idx - 1;
      adc_dout = adc_cur[adc_idx];
    end
  end

  int   cyc        = 0;
  int   ovr_pulses = 0;
  int   cs_falls   = 0;
  int   cs_rises   = 0;
  logic prev_cs    = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (overrun) ovr_pulses++;
    if (prev_cs && !adc_cs_n) cs_falls++;
    if (!prev_cs && adc_cs_n) cs_rises++;
    prev_cs = adc_cs_n;
  end

  task automatic wait_cs(input logic lvl, input int lim, input string tag);
    int n = 0;
    while (adc_cs_n !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(adc_cs_n), 32'(lvl));
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_rises(input int target, input int lim);
    int   n      = 0;
    int   rises  = 0;
    logic prev_s = 1'b0;
    while (rises < target && n < lim) begin
      if (adc_sclk && !prev_s) rises++;
      prev_s = adc_sclk;
      @(negedge clk);
      n++;
    end
    check("sclk rise wait", 32'(rises), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          low;
    int          rises;
    int          k;
    int          snap;
    int          snap2;
    logic        prev_s;
    int          t_rise[3];
    logic [15:0] t2_words[3];

    // ---------------- reset values ----------------
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst sclk",      32'(adc_sclk),      32'd0);
    check("rst cs_n",      32'(adc_cs_n),      32'd1);
    check("rst dout",      32'(dout),          32'd0);
    check("rst valid",     32'(dout_valid),    32'd0);
    check("rst busy",      32'(busy),          32'd0);
    check("rst overrun",   32'(overrun),       32'd0);
    check("rst ovr_count", 32'(overrun_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- 1: single frame from an enable pulse ----------------
    adc_q.push_back(16'hA5C3);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_cs(1'b0, 50, "t1 cs fall");
    low = 0; rises = 0; prev_s = 1'b0;
    while (adc_cs_n == 1'b0 && low < 500) begin
      low++;
      if (adc_sclk && !prev_s) rises++;
      prev_s = adc_sclk;
      @(negedge clk);
    end
    check("t1 cs low cycles", 32'(low),   32'd68);
    check("t1 sclk rises",    32'(rises), 32'd16);
    check("t1 valid at cs rise", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("t1 dout",  32'(dout),       32'h0000A5C3);
    check("t1 valid", 32'(dout_valid), 32'd1);
    k = 1;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t1 busy drop delay", 32'(k), 32'd16);

    // ---------------- 2: continuous, consumer always ready ----------------
    dout_ready = 1'b1;
    @(negedge clk);
    t2_words[0] = 16'h0001;
    t2_words[1] = 16'h8000;
    t2_words[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) adc_q.push_back(t2_words[i]);
    snap   = ovr_pulses;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cs(1'b0, 200, "t2 cs fall");
      wait_cs(1'b1, 200, "t2 cs rise");
      t_rise[i] = cyc;
      @(negedge clk);
      check("t2 dout",  32'(dout),       32'(t2_words[i]));
      check("t2 valid", 32'(dout_valid), 32'd1);
      if (i == 2) enable = 1'b0;
    end
    check("t2 rise spacing a", 32'(t_rise[1] - t_rise[0]), 32'd84);
    check("t2 rise spacing b", 32'(t_rise[2] - t_rise[1]), 32'd84);
    wait_idle(200, "t2 idle");
    check("t2 overrun pulses", 32'(ovr_pulses - snap), 32'd0);
    check("t2 ovr_count",      32'(overrun_count),     32'd0);

    // ---------------- 3: consumer stalled for three frames ----------------
    dout_ready = 1'b0;
    adc_q.push_back(16'h1111);
    adc_q.push_back(16'h2222);
    adc_q.push_back(16'h3333);
    snap   = ovr_pulses;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cs(1'b0, 200, "t3 cs fall");
      wait_cs(1'b1, 200, "t3 cs rise");
      @(negedge clk);
      check("t3 dout held", 32'(dout),       32'h00001111);
      check("t3 valid",     32'(dout_valid), 32'd1);
      if (i == 2) enable = 1'b0;
    end
    wait_idle(200, "t3 idle");
    check("t3 overrun pulses", 32'(ovr_pulses - snap), 32'd2);
    check("t3 ovr_count",      32'(overrun_count),     32'd2);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    @(negedge clk);
    check("t3 valid after accept", 32'(dout_valid), 32'd0);
    repeat (20) @(negedge clk);
    check("t3 valid stays low", 32'(dout_valid), 32'd0);

    // ---------------- 4: accept coincides with delivery ----------------
    adc_q.push_back(16'h4444);
    adc_q.push_back(16'h5555);
    snap   = ovr_pulses;
    enable = 1'b1;
    wait_cs(1'b0, 200, "t4 cs fall a");
    wait_cs(1'b1, 200, "t4 cs rise a");
    @(negedge clk);
    check("t4 first dout", 32'(dout), 32'h00004444);
    wait_cs(1'b0, 200, "t4 cs fall b");
    wait_cs(1'b1, 200, "t4 cs rise b");
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    enable     = 1'b0;
    check("t4 new dout",  32'(dout),       32'h00005555);
    check("t4 new valid", 32'(dout_valid), 32'd1);
    wait_idle(200, "t4 idle");
    check("t4 overrun pulses", 32'(ovr_pulses - snap), 32'd0);
    check("t4 ovr_count",      32'(overrun_count),     32'd2);

    // ---------------- 5: reset during bit 7 ----------------
    adc_q.push_back(16'h6666);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_cs(1'b0, 50, "t5 cs fall");
    wait_rises(8, 500);
    rst_n = 1'b0;
    #1;
    check("t5 cs_n in reset",  32'(adc_cs_n),      32'd1);
    check("t5 sclk in reset",  32'(adc_sclk),      32'd0);
    check("t5 valid in reset", 32'(dout_valid),    32'd0);
    check("t5 busy in reset",  32'(busy),          32'd0);
    check("t5 ovr_count rst",  32'(overrun_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap  = cs_falls;
    repeat (200) @(negedge clk);
    check("t5 no new frame", 32'(cs_falls - snap), 32'd0);
    check("t5 no word",      32'(dout_valid),      32'd0);

    // ---------------- 6: enable dropped during bit 3 ----------------
    dout_ready = 1'b1;
    adc_q.push_back(16'h7777);
    enable = 1'b1;
    wait_cs(1'b0, 50, "t6 cs fall");
    wait_rises(4, 200);
    enable = 1'b0;
    wait_cs(1'b1, 200, "t6 cs rise");
    @(negedge clk);
    check("t6 dout",  32'(dout),       32'h00007777);
    check("t6 valid", 32'(dout_valid), 32'd1);
    snap = cs_falls;
    wait_idle(200, "t6 idle");
    repeat (200) @(negedge clk);
    check("t6 no further frame", 32'(cs_falls - snap), 32'd0);

    // ---------------- overrun counter saturation ----------------
    dout_ready = 1'b0;
    snap   = ovr_pulses;
    snap2  = cs_rises;
    enable = 1'b1;
    k = 0;
    while ((cs_rises - snap2) < 258 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    enable = 1'b0;
    wait_idle(200, "sat idle");
    check("sat frames",          32'(cs_rises - snap2),  32'd258);
    check("sat overrun pulses",  32'(ovr_pulses - snap), 32'd257);
    check("sat ovr_count",       32'(overrun_count),     32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- SPI-style read engine for the sensing ADC: generates adc_sclk and adc_cs_n from the 100 MHz system clock, shifts adc_dout in MSB-first, and presents each completed sample on a valid/ready word interface.
- Sits between the ADC pins on the y-bus and the SDRAM FIFO write port. It is the receive counterpart of the serial DAC load path.
- Runs continuously while enabled, or for one frame per trigger.

Parameters:
- CLK_DIV, 200, clk cycles per adc_sclk period; even, >= 4; half period H = CLK_DIV/2.
- FRAME_BITS, 16, sclk pulses per frame (cs_n low window); >= DATA_BITS.
- DATA_BITS, 16, width of dout; the last DATA_BITS bits of each frame are kept.
- GAP_PERIODS, 4, sclk periods cs_n is held high between frames; >= 1.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, reset: asynchronous, active-low.
- enable, input, 1, level; continuous acquisition while high.
- start_trig, input, 1, one-cycle pulse; requests a single frame when enable is low.
- adc_dout, input, 1, serial data from the ADC; already synchronised to clk.
- adc_sclk, output, 1, serial clock to the ADC; idles low.
- adc_cs_n, output, 1, chip select to the ADC; idles high.
- dout, output, DATA_BITS, sample word.
- dout_valid, output, 1, dout holds an unconsumed word.
- dout_ready, input, 1, consumer accepts dout on a cycle where dout_valid and dout_ready are both high.
- busy, output, 1, high in every state other than IDLE.
- overrun, output, 1, one-cycle pulse when a completed word is dropped.
- overrun_count, output, 8, dropped-word count; saturates at 255.

Behaviour:

Reset values (rst low):
- adc_sclk = 0, adc_cs_n = 1.
- dout = 0, dout_valid = 0, busy = 0.
- overrun = 0, overrun_count = 0.
- State is IDLE and all counters are cleared.
- Reset asserted mid-frame aborts immediately: cs_n goes high and the partial word is discarded.

FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE -> SETUP when enable = 1 or start_trig = 1.
- SETUP: cs_n low, sclk low, for H cycles. Then go to SHIFT.
- SHIFT: FRAME_BITS bit periods. Each bit period is sclk high for H cycles, then sclk low for H cycles.
  - adc_dout is sampled on the clk cycle in which sclk rises, and shifted into the LSB of the shift register (MSB-first frame).
  - After the last low phase, go to HOLD.
- HOLD: cs_n still low, sclk low, for H cycles.
  - On exit, cs_n goes high and the word is delivered (see output rules).
  - Then go to GAP.
- GAP: cs_n high for GAP_PERIODS*CLK_DIV cycles.
  - Exit to SETUP if enable = 1.
  - Otherwise exit to IDLE.

Frame timing:
- cs_n low window = H + FRAME_BITS*CLK_DIV + H clk cycles.
- Frame period = cs_n low window + GAP_PERIODS*CLK_DIV clk cycles.

Enable and trigger:
- Deasserting enable mid-frame does not abort; the current frame completes, then the block returns to IDLE after GAP.
- start_trig outside IDLE is ignored.
- start_trig with enable = 1 is the same as enable alone.

Output rules (single-entry output register):
- Word delivery happens on the cycle cs_n rises.
- If dout_valid = 0, or dout_ready = 1 on that same cycle:
  - dout is loaded with the low DATA_BITS bits of the shift register.
  - dout_valid = 1 on the next cycle.
- If dout_valid = 1 and dout_ready = 0 on that cycle:
  - The new word is dropped and dout is unchanged.
  - overrun pulses for one cycle.
  - overrun_count increments unless it is already 255.
- A handshake with no new word arriving clears dout_valid on the next cycle.
- dout is stable while dout_valid = 1 and dout_ready = 0.

Decomposition:
- Shared package bioee_adc_pkg holds:
  - the state encoding typedef (IDLE, SETUP, SHIFT, HOLD, GAP);
  - the default constants CLK_DIV_DEFAULT = 200 and ADC_FRAME_BITS = 16.
- One sub-module, sclk_phase_gen:
  - Divides clk by H.
  - Emits rise_tick and fall_tick pulses.
  - Drives adc_sclk, gated by SHIFT.
- The FSM, shift register, output register and overrun counter live in the top level.

Test Plan:
1. CLK_DIV = 4, FRAME_BITS = 16; enable pulsed high for 1 cycle; ADC model drives 0xA5C3 MSB-first, changing on falling edges.
   -> cs_n is low for exactly 68 cycles, with exactly 16 sclk rising edges.
   -> dout = 0xA5C3 with dout_valid = 1 on the cycle after cs_n rises.
   -> busy drops 16 cycles later.
2. enable held high, dout_ready = 1; ADC sends 0x0001, 0x8000, 0xFFFF.
   -> Three words are delivered in order.
   -> cs_n rising edges are 84 cycles apart.
   -> overrun stays 0.
3. enable held high, dout_ready = 0 for 3 frames.
   -> The first word is held on dout.
   -> overrun pulses twice; overrun_count = 2.
   -> After dout_ready = 1 for one cycle, dout_valid = 0 until the next frame.
4. Word completes on the same cycle that dout_ready = 1 while dout_valid = 1.
   -> The old word is consumed, the new word is loaded, and no overrun occurs.
5. Assert rst low during bit 7 of a frame.
   -> cs_n = 1 and sclk = 0 immediately.
   -> dout_valid = 0.
   -> After release, no word appears until a new enable or start_trig.
6. Drop enable during bit 3.
   -> The frame completes and its word is delivered.
   -> The block returns to IDLE; no further cs_n low edge occurs.
   -> overrun_count saturates at 255 in a long run with dout_ready held low.
